// File: rtl/mem_pkg.sv
// mem_pkg: funct3 codes, FSM state encoding, RAM geometry and request legality check
package mem_pkg;
  localparam int RAM_AW_DEF = 10;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  function automatic logic is_err(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic ill, mis;
    ill = we ? (f3 > F3_W) : (f3 == 3'b011 || f3[2:1] == 2'b11);
    mis = ((f3 == F3_H || f3 == F3_HU) && a[0]) || (f3 == F3_W && a != 2'b00);
    return ill || mis;
  endfunction
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/response handshake between the memory stage and the unit
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  modport master (output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
                  input req_ready, resp_valid, resp_rdata, resp_err);
  modport slave  (input req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
                  output req_ready, resp_valid, resp_rdata, resp_err);
endinterface

// File: rtl/dist_ram.sv
// dist_ram: word-addressed RAM with synchronous write and combinational read
module dist_ram #(parameter int AW = 10) (
  input  logic          clk,
  input  logic          write_enable,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   data_write,
  output logic [31:0]   data_out
);
  logic [31:0] mem [2**AW];
  // write port commits on the rising edge
  always_ff @(posedge clk) if (write_enable) mem[addr] <= data_write;
  assign data_out = mem[addr];
endmodule

// File: rtl/mem_access_unit_align.sv
// lsu_align: little-endian lane extract/extend for loads and lane merge for sub-word stores
module lsu_align import mem_pkg::*; (
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);
  logic [31:0] sh, mask;
  // shift the addressed lane down for loads, build the lane mask up for stores
  always_comb begin
    sh      = word_i >> {lane_i, 3'b000};
    load_o  = funct3_i == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
              funct3_i == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
              funct3_i == F3_BU ? {24'b0, sh[7:0]} :
              funct3_i == F3_HU ? {16'b0, sh[15:0]} : word_i;
    mask    = (funct3_i == F3_B ? 32'h0000_00FF : funct3_i == F3_H ? 32'h0000_FFFF : 32'hFFFF_FFFF)
              << {lane_i, 3'b000};
    merge_o = (word_i & ~mask) | ((wdata_i << {lane_i, 3'b000}) & mask);
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32 load/store initiator for dist_ram with read-modify-write sub-word stores
module mem_access_unit import mem_pkg::*; #(parameter int RAM_AW = RAM_AW_DEF) (
  input  logic              clk,
  input  logic              rstn,
  mem_access_unit_if.slave  bus,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);
  state_t      state_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q, load_d, merge_d;
  lsu_align u_align (
    .word_i(ram_rdata), .wdata_i(wdata_q), .lane_i(lane_q), .funct3_i(f3_q),
    .load_o(load_d), .merge_o(merge_d)
  );
  // request FSM; every handshake and RAM output is registered here
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= IDLE;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
      ram_we         <= 1'b0;
      ram_addr       <= '0;
      ram_wdata      <= '0;
      we_q           <= 1'b0;
      f3_q           <= '0;
      lane_q         <= '0;
      wdata_q        <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.req_valid) begin
          we_q          <= bus.req_we;
          f3_q          <= bus.req_funct3;
          lane_q        <= bus.req_addr[1:0];
          wdata_q       <= bus.req_wdata;
          ram_addr      <= bus.req_addr[RAM_AW+1:2];
          bus.req_ready <= 1'b0;
          if (is_err(bus.req_we, bus.req_funct3, bus.req_addr[1:0])) begin
            state_q        <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b1;
            bus.resp_rdata <= '0;
          end else if (bus.req_we && bus.req_funct3 == F3_W) begin
            state_q   <= WRITE;
            ram_we    <= 1'b1;
            ram_wdata <= bus.req_wdata;
          end else state_q <= READ;
        end
        READ: if (we_q) begin
          state_q   <= WRITE;
          ram_we    <= 1'b1;
          ram_wdata <= merge_d;
        end else begin
          state_q        <= RESP;
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= load_d;
        end
        WRITE: begin
          state_q        <= RESP;
          ram_we         <= 1'b0;
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= '0;
        end
        default: if (bus.resp_ready) begin
          state_q        <= IDLE;
          bus.resp_valid <= 1'b0;
          bus.req_ready  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed load/store sequence with a response scoreboard against dist_ram
module tb_mem_access_unit;
  import mem_pkg::*;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [9:0]  last_wa;
  int          errors = 0;
  int          checks = 0;
  logic [32:0] exp_q [$];
  mem_access_unit_if bus();
  mem_access_unit #(.RAM_AW(10)) dut (
    .clk(clk), .rstn(rstn), .bus(bus),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );
  dist_ram #(.AW(10)) u_ram (
    .clk(clk), .write_enable(ram_we), .addr(ram_addr), .data_write(ram_wdata), .data_out(ram_rdata)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic op(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] wd, input logic [31:0] er, input logic ee,
                    input int elat, input int ewe, input int hold);
    int lat, wes;
    logic [32:0] e;
    exp_q.push_back({ee, er});
    @(negedge clk);
    chk({tag, "_req_ready"}, {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = a; bus.req_wdata = wd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1; wes = 0;
    while (lat < 20) begin
      if (ram_we) begin wes++; last_wa = ram_addr; end
      if (bus.resp_valid) break;
      @(negedge clk); lat++;
    end
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_we_cycles"}, wes, ewe);
    e = exp_q.pop_front();
    chk({tag, "_rdata"}, bus.resp_rdata, e[31:0]);
    chk({tag, "_err"}, {31'b0, bus.resp_err}, {31'b0, e[32]});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold"}, {bus.resp_valid, bus.req_ready, bus.resp_rdata[29:0]},
          {2'b10, e[29:0]});
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk({tag, "_release"}, {30'b0, bus.resp_valid, bus.req_ready}, 32'd1);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.resp_ready = 1'b0; last_wa = '0;
    #12;
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst_resp", {bus.resp_valid, bus.resp_err, ram_we, 29'b0}, 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    chk("rst_ram_addr", {22'b0, ram_addr}, 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    @(negedge clk); rstn = 1'b1;
    op("t1_sw", 1'b1, F3_W, 32'hDC, 32'd23, 32'd0, 1'b0, 2, 1, 0);
    chk("t1_word", {22'b0, last_wa}, 32'd55);
    op("t1_lw", 1'b0, F3_W, 32'hDC, 32'h0, 32'd23, 1'b0, 2, 0, 0);
    op("t1_alias", 1'b0, F3_W, 32'h10DC, 32'h0, 32'd23, 1'b0, 2, 0, 0);
    op("t2_sw", 1'b1, F3_W, 32'h100, 32'h11223344, 32'd0, 1'b0, 2, 1, 0);
    op("t2_sb", 1'b1, F3_B, 32'h102, 32'hFFFFFFAB, 32'd0, 1'b0, 3, 1, 0);
    op("t2_lw", 1'b0, F3_W, 32'h100, 32'h0, 32'h11AB3344, 1'b0, 2, 0, 0);
    op("t2_lb", 1'b0, F3_B, 32'h102, 32'h0, 32'hFFFFFFAB, 1'b0, 2, 0, 0);
    op("t2_lbu", 1'b0, F3_BU, 32'h102, 32'h0, 32'h000000AB, 1'b0, 2, 0, 0);
    op("t3_sw0", 1'b1, F3_W, 32'h200, 32'h0, 32'd0, 1'b0, 2, 1, 0);
    op("t3_sh", 1'b1, F3_H, 32'h202, 32'h00008001, 32'd0, 1'b0, 3, 1, 0);
    op("t3_lh", 1'b0, F3_H, 32'h202, 32'h0, 32'hFFFF8001, 1'b0, 2, 0, 0);
    op("t3_lhu", 1'b0, F3_HU, 32'h202, 32'h0, 32'h00008001, 1'b0, 2, 0, 0);
    op("t3_lw", 1'b0, F3_W, 32'h200, 32'h0, 32'h80010000, 1'b0, 2, 0, 0);
    op("t4_lw_mis", 1'b0, F3_W, 32'h101, 32'h0, 32'd0, 1'b1, 1, 0, 0);
    op("t4_sh_mis", 1'b1, F3_H, 32'h103, 32'h5555, 32'd0, 1'b1, 1, 0, 0);
    op("t4_f3_011", 1'b0, 3'b011, 32'h100, 32'h0, 32'd0, 1'b1, 1, 0, 0);
    op("t4_st_f3_100", 1'b1, 3'b100, 32'h100, 32'h77, 32'd0, 1'b1, 1, 0, 0);
    op("t4_lw_after", 1'b0, F3_W, 32'h100, 32'h0, 32'h11AB3344, 1'b0, 2, 0, 0);
    op("t5_hold", 1'b0, F3_LW_HOLD(), 32'h100, 32'h0, 32'h11AB3344, 1'b0, 2, 0, 5);
    op("t6_sw", 1'b1, F3_W, 32'h300, 32'hCAFEBABE, 32'd0, 1'b0, 2, 1, 0);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_B; bus.req_addr = 32'h301;
    bus.req_wdata = 32'h12;
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int i = 0; i < 10 && !ram_we; i++) @(negedge clk);
    chk("t6_we_seen", {31'b0, ram_we}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("t6_we_drop", {31'b0, ram_we}, 32'd0);
    chk("t6_req_ready", {31'b0, bus.req_ready}, 32'd1);
    @(negedge clk); rstn = 1'b1;
    op("t6_lw", 1'b0, F3_W, 32'h300, 32'h0, 32'hCAFEBABE, 1'b0, 2, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic logic [2:0] F3_LW_HOLD();
    return F3_W;
  endfunction
endmodule
